// File: rtl/f1_delay_responder.sv
// f1_delay_responder
// Responder side of the F1 start-light command interface. Arms a pseudo-random
// lights-out delay (in tick strobes) on a cmd_delay rising edge, pulses
// delay_done at lights out, then times the player's reaction in ticks.
// A button press before lights out is recorded as a sticky false start.
//
// Handshake: there is no valid/ready pair here. cmd_delay is a level whose
// rising edge is a one-shot request, honoured only in IDLE. delay_done and
// react_valid are single-cycle registered strobes with no back-pressure.
// en_out is purely combinational and follows its mux every cycle.
module f1_delay_responder #(
    parameter int LFSR_W  = 7,
    parameter int REACT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               cmd_seq,
    input  logic               cmd_delay,
    input  logic               button,
    output logic               en_out,
    output logic               delay_done,
    output logic [LFSR_W-1:0]  delay_k,
    output logic [LFSR_W-1:0]  lfsr_out,
    output logic               busy,
    output logic [REACT_W-1:0] react_count,
    output logic               react_valid,
    output logic               false_start,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_REACT = 2'd2
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [LFSR_W-1:0]  lfsr;
    logic [LFSR_W-1:0]  dcnt;
    logic [REACT_W-1:0] rcnt;
    logic               cmd_delay_q;
    logic               arm;

    // Control strobes decoded by the FSM and consumed by the datapath.
    logic load_delay;
    logic dec_delay;
    logic fire_done;
    logic set_false;
    logic capture;
    logic inc_react;

    assign arm       = cmd_delay & ~cmd_delay_q;
    assign lfsr_out  = lfsr;
    assign busy      = (state != S_IDLE);
    assign en_out    = cmd_seq ? tick : delay_done;
    assign dbg_state = state;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and control decode; button is checked before tick.
    always_comb begin
        state_n    = state;
        load_delay = 1'b0;
        dec_delay  = 1'b0;
        fire_done  = 1'b0;
        set_false  = 1'b0;
        capture    = 1'b0;
        inc_react  = 1'b0;
        case (state)
            S_IDLE: begin
                if (arm) begin
                    load_delay = 1'b1;
                    state_n    = S_DELAY;
                end
            end
            S_DELAY: begin
                if (button) begin
                    set_false = 1'b1;
                    state_n   = S_IDLE;
                end else if (tick) begin
                    if (dcnt == LFSR_W'(1)) begin
                        fire_done = 1'b1;
                        state_n   = S_REACT;
                    end else begin
                        dec_delay = 1'b1;
                    end
                end
            end
            S_REACT: begin
                if (button) begin
                    capture = 1'b1;
                    state_n = S_IDLE;
                end else if (tick) begin
                    inc_react = 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Datapath: free-running LFSR, edge detect, delay/reaction counters and
    // the registered output strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr        <= LFSR_W'(1);
            cmd_delay_q <= 1'b0;
            delay_k     <= '0;
            dcnt        <= '0;
            rcnt        <= '0;
            delay_done  <= 1'b0;
            react_valid <= 1'b0;
            react_count <= '0;
            false_start <= 1'b0;
        end else begin
            lfsr        <= {lfsr[LFSR_W-2:0], lfsr[LFSR_W-1] ^ lfsr[2]};
            cmd_delay_q <= cmd_delay;
            delay_done  <= fire_done;
            react_valid <= capture;
            if (load_delay) begin
                delay_k     <= lfsr;
                dcnt        <= lfsr;
                false_start <= 1'b0;
            end
            if (dec_delay) begin
                dcnt <= dcnt - LFSR_W'(1);
            end
            if (fire_done) begin
                rcnt <= '0;
            end
            // Reaction time saturates rather than wrapping.
            if (inc_react && (rcnt != {REACT_W{1'b1}})) begin
                rcnt <= rcnt + REACT_W'(1);
            end
            if (set_false) begin
                false_start <= 1'b1;
            end
            if (capture) begin
                react_count <= rcnt;
            end
        end
    end

endmodule

// File: tb/tb_f1_delay_responder.sv
// Bench for f1_delay_responder: a reference model advanced on every clock,
// a scoreboard queue of expected reaction counts, and a narrow-counter
// second instance that exercises reaction saturation.
module tb_f1_delay_responder;

    logic        clk;
    logic        rst;
    logic        tick;
    logic        cmd_seq;
    logic        cmd_delay;
    logic        button;

    logic        en_out;
    logic        delay_done;
    logic [6:0]  delay_k;
    logic [6:0]  lfsr_out;
    logic        busy;
    logic [15:0] react_count;
    logic        react_valid;
    logic        false_start;
    logic [1:0]  dbg_state;

    logic        s_en_out;
    logic        s_delay_done;
    logic [6:0]  s_delay_k;
    logic [6:0]  s_lfsr_out;
    logic        s_busy;
    logic [3:0]  s_react_count;
    logic        s_react_valid;
    logic        s_false_start;
    logic [1:0]  s_dbg_state;

    int total;
    int bad;
    bit mon_on;

    // Reference model state (reflects the DUT after the most recent edge).
    int          m_cyc;
    int          m_state;
    logic [6:0]  m_lfsr;
    logic [6:0]  m_k;
    logic [6:0]  m_dcnt;
    logic [15:0] m_rcnt;
    logic [15:0] m_rc;
    logic        m_cd_q;
    logic        m_fs;
    logic        m_dd;
    logic        m_rv;

    logic [15:0] exp_q[$];
    logic [3:0]  exp_s_q[$];

    f1_delay_responder #(.LFSR_W(7), .REACT_W(16)) dut (
        .clk(clk), .rst(rst), .tick(tick), .cmd_seq(cmd_seq),
        .cmd_delay(cmd_delay), .button(button), .en_out(en_out),
        .delay_done(delay_done), .delay_k(delay_k), .lfsr_out(lfsr_out),
        .busy(busy), .react_count(react_count), .react_valid(react_valid),
        .false_start(false_start), .dbg_state(dbg_state)
    );

    f1_delay_responder #(.LFSR_W(7), .REACT_W(4)) dut_s (
        .clk(clk), .rst(rst), .tick(tick), .cmd_seq(cmd_seq),
        .cmd_delay(cmd_delay), .button(button), .en_out(s_en_out),
        .delay_done(s_delay_done), .delay_k(s_delay_k), .lfsr_out(s_lfsr_out),
        .busy(s_busy), .react_count(s_react_count), .react_valid(s_react_valid),
        .false_start(s_false_start), .dbg_state(s_dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, m_cyc);
        end
    endtask

    // Advance the model across one edge using the inputs the DUT samples there.
    task automatic model_edge();
        logic arm;
        m_cyc++;
        m_dd = 1'b0;
        m_rv = 1'b0;
        if (rst) begin
            m_state = 0; m_lfsr = 7'h01; m_k = '0; m_dcnt = '0; m_rcnt = '0;
            m_rc = '0; m_cd_q = 1'b0; m_fs = 1'b0;
        end else begin
            arm = cmd_delay & ~m_cd_q;
            case (m_state)
                0: if (arm) begin
                    m_k = m_lfsr; m_dcnt = m_lfsr; m_fs = 1'b0; m_state = 1;
                end
                1: if (button) begin
                    m_fs = 1'b1; m_state = 0;
                end else if (tick) begin
                    if (m_dcnt == 7'd1) begin
                        m_dd = 1'b1; m_rcnt = '0; m_state = 2;
                    end else begin
                        m_dcnt = m_dcnt - 7'd1;
                    end
                end
                default: if (button) begin
                    m_rv = 1'b1;
                    m_rc = m_rcnt;
                    exp_q.push_back(m_rcnt);
                    exp_s_q.push_back((m_rcnt > 16'd15) ? 4'd15 : m_rcnt[3:0]);
                    m_state = 0;
                end else if (tick && m_rcnt != 16'hFFFF) begin
                    m_rcnt = m_rcnt + 16'd1;
                end
            endcase
            m_cd_q = cmd_delay;
            m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[2]};
        end
    endtask

    // Driver tasks
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic tick_pulses(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            for (int j = 1; j < gap; j++) step();
        end
    endtask

    task automatic press();
        button = 1'b1;
        step();
        button = 1'b0;
    endtask

    task automatic arm_cmd();
        cmd_delay = 1'b0;
        step();
        cmd_delay = 1'b1;
        step();
    endtask

    // Tick until the model leaves DELAY, bounded by the largest possible K.
    task automatic finish_delay();
        for (int i = 0; i < 130 && m_state == 1; i++) tick_pulses(1, 2);
        check("delay_bound", m_state, 2);
    endtask

    // Scoreboard / monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_on) begin
            check("lfsr", lfsr_out, m_lfsr);
            check("delay_k", delay_k, m_k);
            check("busy", busy, m_state != 0);
            check("state", dbg_state, m_state);
            check("false_start", false_start, m_fs);
            check("delay_done", delay_done, m_dd);
            check("en_out", en_out, cmd_seq ? tick : m_dd);
            check("react_valid", react_valid, m_rv);
            check("react_count", react_count, m_rc);
            if (react_valid) begin
                if (exp_q.size() == 0) check("rv_unexpected", 1, 0);
                else check("react_sb", react_count, exp_q.pop_front());
            end
            if (s_react_valid) begin
                if (exp_s_q.size() == 0) check("rv_s_unexpected", 1, 0);
                else check("react_sat_sb", s_react_count, exp_s_q.pop_front());
            end
        end
    end

    initial begin
        total = 0; bad = 0; mon_on = 1'b0; m_cyc = 0; m_state = 0;
        m_lfsr = 7'h01; m_k = '0; m_dcnt = '0; m_rcnt = '0; m_rc = '0;
        m_cd_q = 1'b0; m_fs = 1'b0; m_dd = 1'b0; m_rv = 1'b0;
        rst = 1'b1; tick = 1'b0; cmd_seq = 1'b0; cmd_delay = 1'b0; button = 1'b0;
        repeat (3) step();
        mon_on = 1'b1;
        rst = 1'b0;

        // Reset state and LFSR sequence 01, 02, 04, 09.
        check("rst_lfsr", lfsr_out, 7'h01);
        check("rst_outs", {delay_done, busy, react_valid, false_start, en_out}, 5'b0);
        check("rst_react_count", react_count, 16'h0);
        step(); check("lfsr_seq1", lfsr_out, 7'h02);
        step(); check("lfsr_seq2", lfsr_out, 7'h04);
        step(); check("lfsr_seq3", lfsr_out, 7'h09);

        // Arm at lfsr=09, tick every 4 clocks; level stays high (no re-arm).
        cmd_delay = 1'b1;
        step();
        check("arm_k9", delay_k, 7'h09);
        check("arm_busy", busy, 1'b1);
        tick_pulses(9, 4);
        check("in_react", dbg_state, 2'd2);
        tick_pulses(5, 4);
        press();                        // react count 5
        step(); step();
        check("held_no_rearm", busy, 1'b0);

        // False start after 3 ticks, then re-arm clears it.
        arm_cmd();
        if (m_k > 7'd3) begin
            tick_pulses(3, 2);
            press();
            check("fs_set", false_start, 1'b1);
            check("fs_idle", busy, 1'b0);
        end
        step();
        arm_cmd();
        check("fs_cleared", false_start, 1'b0);
        finish_delay();

        // Saturation: 20 ticks then button (16-bit gives 20, 4-bit gives 15).
        tick_pulses(20, 1);
        press();
        step();

        // Button coinciding with the 6th tick still yields 5.
        arm_cmd();
        finish_delay();
        tick_pulses(5, 2);
        tick = 1'b1; button = 1'b1;
        step();
        tick = 1'b0; button = 1'b0;
        step();

        // Second edge mid-DELAY ignored; reset mid-REACT; en_out mirrors tick.
        arm_cmd();
        cmd_delay = 1'b0;
        step();
        cmd_delay = 1'b1;
        step();
        finish_delay();
        tick_pulses(3, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_react", busy, 1'b0);
        cmd_seq = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick = ($urandom_range(0, 1) == 1);
            step();
        end
        tick = 1'b0;

        // Random mix of all inputs.
        for (int i = 0; i < 1500; i++) begin
            tick      = ($urandom_range(0, 3) == 0);
            button    = ($urandom_range(0, 60) == 0);
            cmd_delay = cmd_delay ^ ($urandom_range(0, 7) == 0);
            cmd_seq   = ($urandom_range(0, 1) == 1);
            rst       = ($urandom_range(0, 400) == 0);
            step();
        end
        rst = 1'b0; tick = 1'b0; button = 1'b0;
        step(); step();

        // Final report
        @(negedge clk);
        mon_on = 1'b0;
        check("sb_drain", exp_q.size(), 0);
        check("sb_s_drain", exp_s_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/f1_delay_responder.md
Name: f1_delay_responder

Overview:
Responder side of the F1 start-light command interface. It receives cmd_seq and cmd_delay from the light-sequence FSM and supplies that FSM's enable. On a cmd_delay rising edge it arms a pseudo-random lights-out delay counted in tick strobes, then pulses delay_done, then measures the player's reaction time in ticks. It also flags a false start if the button is pressed before lights out.

Parameters:
LFSR_W, 7, width of random delay source and of latched delay K
REACT_W, 16, width of reaction counter (saturating)

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
tick  in  1  one-clk time-base strobe (e.g. 1 ms)
cmd_seq  in  1  high: FSM stepping on tick; low: FSM stepping on delay_done
cmd_delay  in  1  level from FSM; rising edge arms the delay
button  in  1  player button, already synchronised, active-high
en_out  out  1  enable to FSM: cmd_seq ? tick : delay_done (combinational)
delay_done  out  1  registered 1-clk pulse at lights out
delay_k  out  LFSR_W  delay value latched at arm
lfsr_out  out  LFSR_W  free-running LFSR state
busy  out  1  high in DELAY or REACT
react_count  out  REACT_W  last captured reaction time in ticks
react_valid  out  1  registered 1-clk pulse when react_count updates
false_start  out  1  sticky; button pressed during DELAY

Behaviour:
- Reset: state IDLE; lfsr=1; delay_k=0; delay/react counters=0; delay_done, react_valid, false_start, busy, react_count=0.
- LFSR: Fibonacci, polynomial x^7+x^3+1 at LFSR_W=7. Each clk: lfsr <= {lfsr[5:0], lfsr[6]^lfsr[2]}. Never zero. Sequence from reset: 01,02,04,09,...
- Edge detect: cmd_delay_q is registered. Arm = cmd_delay & ~cmd_delay_q.
- IDLE: on arm, delay_k <= lfsr_out, dcnt <= lfsr_out, false_start <= 0, go to DELAY. A tick in the arm cycle is not counted.
- DELAY: each tick does dcnt-1. A tick with dcnt==1 sets delay_done=1 on the next clk, clears rcnt, and goes to REACT. delay_done is therefore asserted one clk after the K-th tick.
  - Button high in DELAY (checked before tick): false_start <= 1, go to IDLE, no delay_done.
- REACT: each tick does rcnt+1, saturating at all-ones.
  - Button high: react_count <= rcnt (value before this cycle's increment), react_valid pulses, go to IDLE. Button has priority over a same-cycle tick.
- Arm edges while busy are ignored. A cmd_delay level held high never re-arms.
- rst has priority everywhere. Reset mid-DELAY/REACT returns to IDLE with no pulses and clears outputs.
- en_out follows the mux every cycle, independent of state.

Test Plan:
1. Release rst, no stimulus: all outputs 0 at reset. lfsr_out goes 01→02→04→09 over 3 clks.
2. Arm when lfsr_out=7'h09, tick every 4 clks: delay_k=9, busy=1. delay_done pulses once, 1 clk after the 9th tick. en_out equals delay_done with cmd_seq=0.
3. Arm, then button after 3 ticks in DELAY: false_start=1, busy=0, no delay_done, react_valid=0. Re-arm clears false_start.
4. After delay_done, 5 ticks then button: react_valid pulses once, react_count=5. A button coinciding with the 6th tick still gives 5.
5. REACT_W=4, 20 ticks then button: react_count=15 (saturated).
6. Second cmd_delay edge mid-DELAY: ignored, delay_k unchanged. rst mid-REACT: IDLE, no react_valid. cmd_seq=1: en_out mirrors tick.
